// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Elastic two-entry (main + skid) pipeline stage register with
//               valid/ready handshake, flush and NOP bubble masking.
//               Optional performance counters under PIPE_STAGE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int              PC_W      = 8,
    parameter int              IR_W      = 32,
    parameter int              PAYLOAD_W = 96,
    parameter int              CTRL_W    = 10,
    parameter logic [IR_W-1:0] NOP_IR    = 32'h0000_0000,
    parameter int              CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [IR_W-1:0]      in_ir,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [IR_W-1:0]      out_ir,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [CTRL_W-1:0]    out_ctrl,
    input  logic                 flush,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic                 r_m_valid;
    logic                 r_s_valid;
    logic [PC_W-1:0]      r_m_pc;
    logic [IR_W-1:0]      r_m_ir;
    logic [PAYLOAD_W-1:0] r_m_data;
    logic [CTRL_W-1:0]    r_m_ctrl;
    logic [PC_W-1:0]      r_s_pc;
    logic [IR_W-1:0]      r_s_ir;
    logic [PAYLOAD_W-1:0] r_s_data;
    logic [CTRL_W-1:0]    r_s_ctrl;

    logic w_accept;
    logic w_pop;
    logic w_m_load_in;
    logic w_m_load_s;
    logic w_s_load;

    // S can only be occupied while M is, so !S.valid alone decides acceptance.
    assign w_accept    = in_valid & ~r_s_valid;
    assign w_pop       = r_m_valid & out_ready;
    assign w_m_load_in = ~flush & w_accept & (~r_m_valid | (w_pop & ~r_s_valid));
    assign w_m_load_s  = ~flush & w_pop & r_s_valid;
    assign w_s_load    = ~flush & w_accept & r_m_valid & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!r_m_valid) begin
            r_m_valid <= w_accept;
        end else if (w_pop) begin
            if (r_s_valid) begin
                r_s_valid <= 1'b0;
            end else begin
                r_m_valid <= w_accept;
            end
        end else if (w_accept) begin
            r_s_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_pc   <= '0;
            r_m_ir   <= '0;
            r_m_data <= '0;
            r_m_ctrl <= '0;
        end else if (w_m_load_s) begin
            r_m_pc   <= r_s_pc;
            r_m_ir   <= r_s_ir;
            r_m_data <= r_s_data;
            r_m_ctrl <= r_s_ctrl;
        end else if (w_m_load_in) begin
            r_m_pc   <= in_pc;
            r_m_ir   <= in_ir;
            r_m_data <= in_data;
            r_m_ctrl <= in_ctrl;
        end
    end

    // Skid payload is never observed while invalid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_s_load) begin
            r_s_pc   <= in_pc;
            r_s_ir   <= in_ir;
            r_s_data <= in_data;
            r_s_ctrl <= in_ctrl;
        end
    end

    assign in_ready  = ~r_s_valid;
    assign out_valid = r_m_valid;
    assign out_pc    = r_m_pc;
    assign out_data  = r_m_data;
    assign out_ir    = r_m_valid ? r_m_ir : NOP_IR;
    assign out_ctrl  = r_m_valid ? r_m_ctrl : '0;

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_m_valid && !out_ready && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (!r_m_valid && (r_bubble_cnt != c_cnt_max)) begin
                r_bubble_cnt <= r_bubble_cnt + c_cnt_one;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Testbench for pipe_stage_reg: directed scenarios plus randomized traffic
// compared against a two-deep FIFO reference model.
module tb_pipe_stage_reg;

    localparam int PC_W      = 8;
    localparam int IR_W      = 32;
    localparam int PAYLOAD_W = 96;
    localparam int CTRL_W    = 10;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam logic [IR_W-1:0] NOP_IR = 32'h0000_0000;
    localparam int VW = 2 + PC_W + IR_W + PAYLOAD_W + CTRL_W + 2 * CNT_W;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [PC_W-1:0]      in_pc = '0;
    logic [IR_W-1:0]      in_ir = '0;
    logic [PAYLOAD_W-1:0] in_data = '0;
    logic [CTRL_W-1:0]    in_ctrl = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [PC_W-1:0]      out_pc;
    logic [IR_W-1:0]      out_ir;
    logic [PAYLOAD_W-1:0] out_data;
    logic [CTRL_W-1:0]    out_ctrl;
    logic                 flush = 1'b0;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     bubble_cnt;

    pipe_stage_reg #(
        .PC_W(PC_W), .IR_W(IR_W), .PAYLOAD_W(PAYLOAD_W), .CTRL_W(CTRL_W),
        .NOP_IR(NOP_IR), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ir(in_ir), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ir(out_ir), .out_data(out_data), .out_ctrl(out_ctrl),
        .flush(flush), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [IR_W-1:0]      ir;
        logic [PAYLOAD_W-1:0] data;
        logic [CTRL_W-1:0]    ctrl;
    } beat_t;

    // Reference model: a FIFO of capacity two plus saturating counters.
    beat_t q[$];
    beat_t last;
    int    stall_m;
    int    bubble_m;
    int    vectors = 0;
    int    miscompares = 0;

    logic [VW-1:0] obs;
    assign obs = {out_valid, in_ready, out_pc, out_ir, out_data, out_ctrl, stall_cnt, bubble_cnt};

    function automatic logic [VW-1:0] expected_vec();
        logic              v;
        logic [IR_W-1:0]   ir;
        logic [CTRL_W-1:0] ctrl;
        logic [CNT_W-1:0]  st;
        logic [CNT_W-1:0]  bu;
        v    = (q.size() > 0);
        ir   = v ? q[0].ir : NOP_IR;
        ctrl = v ? q[0].ctrl : '0;
`ifdef PIPE_STAGE_PERF_EN
        st = CNT_W'(stall_m);
        bu = CNT_W'(bubble_m);
`else
        st = '0;
        bu = '0;
`endif
        return {v, (q.size() < 2), last.pc, ir, last.data, ctrl, st, bu};
    endfunction

    task automatic model_reset();
        q.delete();
        last     = '0;
        stall_m  = 0;
        bubble_m = 0;
    endtask

    task automatic model_edge();
        int    n;
        beat_t b;
        n = q.size();
        if (n > 0 && !out_ready && stall_m < CNT_MAX) stall_m++;
        if (n == 0 && bubble_m < CNT_MAX) bubble_m++;
        if (flush) begin
            q.delete();
        end else begin
            if (n > 0 && out_ready) void'(q.pop_front());
            if (in_valid && n < 2) begin
                b.pc = in_pc; b.ir = in_ir; b.data = in_data; b.ctrl = in_ctrl;
                q.push_back(b);
            end
        end
        if (q.size() > 0) last = q[0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic offer(input logic v, input logic [PC_W-1:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_ir    = $urandom | 32'h1;
        in_data  = {$urandom, $urandom, $urandom};
        in_ctrl  = CTRL_W'($urandom) | 10'h1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] exp;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp = expected_vec();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_values: got %h expected %h", obs, exp);
        end
        tick();
    endtask

    task automatic test_stream();
        logic [VW-1:0] exp;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            offer(i < 4, PC_W'(i * 4));
            tick();
            exp = expected_vec();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL stream[%0d]: got %h expected %h", i, obs, exp);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] exp;
        out_ready = 1'b0;
        offer(1'b1, 8'h10);
        tick();
        offer(1'b1, 8'h14);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || out_pc !== 8'h10 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_full: got rdy=%b pc=%h vld=%b expected rdy=0 pc=10 vld=1",
                     in_ready, out_pc, out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = expected_vec();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL backpressure_drain[%0d]: got %h expected %h", i, obs, exp);
            end
        end
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_empty: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        logic [VW-1:0] exp;
        out_ready = 1'b0;
        offer(1'b1, 8'h20);
        tick();
        offer(1'b1, 8'h24);
        tick();
        offer(1'b1, 8'h28);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_ir !== 32'h0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_clear: got vld=%b ctrl=%h ir=%h rdy=%b expected 0 0 0 1",
                     out_valid, out_ctrl, out_ir, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = expected_vec();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL flush_after[%0d]: got %h expected %h", i, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [VW-1:0] exp;
        out_ready = 1'b0;
        offer(1'b1, 8'h30);
        tick();
        offer(1'b1, 8'h34);
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        exp = expected_vec();
        vectors++;
        if (obs !== exp || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", obs, exp);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        exp = expected_vec();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL async_reset_release: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_counter_saturation();
        logic [VW-1:0]    exp;
        logic [CNT_W-1:0] want;
        out_ready = 1'b0;
        offer(1'b1, 8'h40);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp = expected_vec();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs, exp);
            end
        end
`ifdef PIPE_STAGE_PERF_EN
        want = 4'd15;
`else
        want = 4'd0;
`endif
        vectors++;
        if (stall_cnt !== want) begin
            miscompares++;
            $display("FAIL stall_saturate: got %0d expected %0d", stall_cnt, want);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [VW-1:0] exp;
        for (int i = 0; i < 10000; i++) begin
            offer(($urandom % 4) != 0, PC_W'($urandom));
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 40) == 0;
            exp = expected_vec();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs, exp);
            end
            #2;
            vectors++;
            if (in_ready !== (q.size() < 2)) begin
                miscompares++;
                $display("FAIL random_ready_stable[%0d]: got %b expected %b", i, in_ready, (q.size() < 2));
            end
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_counter_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register for the MIPS32 pipelined datapath. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches with one reusable block. The block carries PC, instruction, datapath payload and control bits under a valid/ready handshake, and holds them in a two-entry skid buffer so that `in_ready` is driven directly from a flop. It also supports flush for branch/jump squash and inserts NOP bubbles whenever it holds nothing valid.

## Interface
- `PC_W`, 8, PC field width
- `IR_W`, 32, instruction field width
- `PAYLOAD_W`, 96, datapath payload width (e.g. rs1/rs2/imm or alu_res/store data)
- `CTRL_W`, 10, control-bit field width (mem_read, mem_write, reg_write, …)
- `NOP_IR`, 32'h0000_0000, instruction value presented during bubbles
- `CNT_W`, 16, performance counter width (used only with the macro)

Ports:
- `clk`, in, 1, sole clock; all state updates on the rising edge
- `reset`, in, 1, asynchronous, active-low; clears all state
- `in_valid`, in, 1, upstream beat present
- `in_ready`, out, 1, stage can accept a beat; registered
- `in_pc`, in, PC_W, upstream PC
- `in_ir`, in, IR_W, upstream instruction
- `in_data`, in, PAYLOAD_W, upstream payload
- `in_ctrl`, in, CTRL_W, upstream control bits
- `out_valid`, out, 1, head entry valid
- `out_ready`, in, 1, downstream accepts head
- `out_pc`, out, PC_W, head PC
- `out_ir`, out, IR_W, head instruction, or NOP_IR when not valid
- `out_data`, out, PAYLOAD_W, head payload
- `out_ctrl`, out, CTRL_W, head control, or all-zero when not valid
- `flush`, in, 1, squash all held and incoming beats
- `stall_cnt`, out, CNT_W, cycles with out_valid & !out_ready (macro only)
- `bubble_cnt`, out, CNT_W, cycles with !out_valid (macro only)

## Operation
- Storage has two entries: main (M, drives the outputs) and skid (S).
- Each entry holds valid, pc, ir, data and ctrl.
- `in_ready` = !S.valid, taken from a flop. Combinational in→out paths are forbidden.
- Accept condition: `in_valid & in_ready`. Pop condition: `out_valid & out_ready`.
- Behaviour per edge, when flush = 0:
  - M empty, accept: beat goes into M.
  - M full, pop, S empty, accept: beat goes into M.
  - M full, no pop, accept: beat goes into S, and `in_ready` falls.
  - Pop with S full: S moves to M and S empties. No accept is possible in this state.
  - Pop, S empty, no accept: M empties.
- Ordering is strict FIFO. No beat is duplicated or dropped except by flush.
- Flush is synchronous and has priority over every other event:
  - On the next edge, M.valid = S.valid = 0.
  - A beat offered in the flush cycle is discarded.
  - A pop in the flush cycle still completes downstream.
- Bubble masking: while `out_valid` = 0, `out_ctrl` = 0 and `out_ir` = NOP_IR. `out_pc` and `out_data` keep their last value and are don't-care.
- Data fields are loaded only on writes, to save power. Valid bits are the only state that is required to reset.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on the outputs after edge N.
- Sustained throughput is 1 beat per cycle when `out_ready` is held at 1.
- Reset values:
  - `in_ready` = 1, `out_valid` = 0.
  - `out_ctrl` = 0, `out_ir` = NOP_IR.
  - `out_pc` = 0, `out_data` = 0.
  - Both counters = 0.
- Reset is asserted asynchronously and deasserted synchronously relative to `clk` by the top level. Reset asserted mid-transfer drops all entries immediately.
- `in_ready` recovers 1 cycle after S drains.
- A flush in cycle N gives `out_valid` = 0 and `in_ready` = 1 in cycle N+1.
- Counters saturate at 2^CNT_W−1 and do not wrap. Counters are cleared only by reset.

## Configuration
- `PIPE_STAGE_PERF_EN`:
  - Defined: `stall_cnt` and `bubble_cnt` are implemented as specified.
  - Undefined: both counter outputs are tied to 0, and no counter flops are synthesised.
- Handshake behaviour is identical in both configurations.

## Test plan
- Reset then stream: hold `out_ready` = 1 and drive pc 0x00,0x04,0x08,0x0C on consecutive cycles. Required: outputs appear 1 cycle later in order, `in_ready` stays 1, and `bubble_cnt` = 1 (the initial empty cycle).
- Backpressure: `out_ready` = 0 while beats A (pc 0x10) and B (pc 0x14) are offered. Required: A holds in M, B goes to S, and `in_ready` = 0. Then raise `out_ready` for 3 cycles. Required: A, B pop in order, then `out_valid` = 0 and `in_ready` = 1.
- Flush with full buffer: M = A, S = B, and flush is asserted while C is offered. Required: next cycle `out_valid` = 0, `out_ctrl` = 0, `out_ir` = 0x00000000, C never appears, and `in_ready` = 1.
- Mid-operation reset: hold 2 entries, pull `reset` low between edges. Required: `out_valid` drops immediately without a clock edge, and all outputs take their reset values.
- Counter saturation (macro defined, CNT_W = 4): hold `out_valid` = 1 with `out_ready` = 0 for 20 cycles. Required: `stall_cnt` = 15 and stays there. With the macro undefined, `stall_cnt` = 0.
- Randomised `in_valid`/`out_ready` over 10k cycles against a scoreboard. Required: no loss, no duplication, no reordering, and `in_ready` never changes except at a clock edge.
